id_bypass_ctrl: RTL and testbench
=================================

# id_bypass_ctrl

Parametrised decode-side front end for the 5-stage pipeline. It owns the IF/ID pipeline register with stall, bubble and flush handling, and an instruction hold buffer. The buffer keeps the SRAM instruction stable across multi-cycle stalls. It also provides an N-source priority operand bypass network with load-use interlock and a saturating stall counter. It sits between IF/instruction SRAM and the decoder, and replaces the fixed two-source forwarding and the raw `inst_sram_rdata` path.

## Interface
- NUM_FWD, 3: number of bypass sources; index 0 = youngest (EX), ascending = older (MEM, WB…).
- DATA_W, 32: register data width.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- stall  in  `StallBus`  pipeline stall bus; bit 1 = IF/ID, bit 2 = ID/EX; `Stop`/`NoStop`.
- flush  in  1  kill instruction in ID.
- if_to_id_bus  in  `IF_TO_ID_WD`  {ce, pc[31:0]}.
- inst_sram_rdata  in  32  instruction SRAM read data.
- use_rs, use_rt  in  1 each  decoder flags: operand actually read.
- rf_rdata1, rf_rdata2  in  DATA_W each  regfile read data for rs/rt.
- fwd_we  in  NUM_FWD  per-source write enable.
- fwd_waddr  in  5*NUM_FWD  per-source destination; source i at [5i+4:5i].
- fwd_wdata  in  DATA_W*NUM_FWD  per-source result.
- fwd_pend  in  NUM_FWD  source i's result not yet available, e.g. load in EX.
- id_valid  out  1  ID holds a live instruction.
- id_pc  out  32  PC of the ID instruction.
- id_inst  out  32  stable instruction word; 0 when !id_valid.
- rs_addr, rt_addr  out  5 each  id_inst[25:21], id_inst[20:16].
- rs_data, rt_data  out  DATA_W each  bypassed operands.
- stallreq  out  1  load-use interlock request.
- stall_cnt  out  CNT_W  saturating count of interlock cycles.

## Operation
- IF/ID register, priority at posedge:
  - rst → 0.
  - flush → 0.
  - stall[1]=Stop & stall[2]=NoStop → 0 (bubble).
  - stall[1]=NoStop → load if_to_id_bus.
  - else hold.
- id_valid = registered ce.
- Hold buffer FSM, states PASS and HELD:
  - PASS: id_inst = inst_sram_rdata.
  - PASS→HELD when the register holds (stall[1]=Stop, stall[2]=Stop, no flush/rst) and id_valid. Capture inst_sram_rdata into hold_r on that edge.
  - HELD: id_inst = hold_r.
  - HELD→PASS on any load, bubble, flush or rst.
  - HELD with continued hold → stay; hold_r unchanged.
- Bypass, per operand:
  - addr 0 → 0.
  - Otherwise the lowest index i with fwd_we[i] & waddr_i==addr supplies wdata_i.
  - No match → rf_rdata.
  - !id_valid → 0.
- Interlock: stallreq = id_valid & ((use_rs & hit_rs & pend_of_winner_rs) | same for rt).
  - Pending status of an older matching source is ignored when a younger source matches.
  - stallreq is independent of flush; the stall controller masks it.
- stall_cnt: +1 each cycle stallreq=1; saturates at all-ones; cleared only by rst.

## Timing
- Reset values: id_valid 0, id_pc 0, id_inst 0, rs_data/rt_data 0, stallreq 0, stall_cnt 0, FSM PASS, hold_r 0.
- IF/ID register: 1-cycle latency.
- id_inst, rs/rt data, stallreq: combinational from registers and current-cycle inputs, no added latency.
- First cycle of a stall: id_inst from SRAM. Subsequent stalled cycles: from hold_r.
- Simultaneous flush and stall[1]=NoStop: flush wins, register cleared.
- Same-cycle duplicate matches: youngest wins.
- Writes to $0 never forwarded.
- rst mid-stall: all state cleared next edge; no stale hold_r use.

## Structure
- `StallBus`, `Stop`, `NoStop`, `IF_TO_ID_WD`: from lib/defines.vh.
- Add `FWD_SRC_WD` (= 1+1+5+DATA_W per source) to the same file.
- One sub-module, id_fwd_sel:
  - Per-operand priority mux plus hit/pend outputs.
  - Instantiated twice (rs, rt), parametrised NUM_FWD/DATA_W.

## Test plan
- Reset, then load {ce=1, pc=0xBFC00000} with inst 0x3C011234 → next cycle id_valid=1, id_pc=0xBFC00000, id_inst=0x3C011234, stallreq=0.
- 3-cycle stall (stall[1]=stall[2]=Stop); SRAM data changes to 0xDEADBEEF after the first edge → id_inst stays 0x3C011234 throughout; PASS resumes on release.
- rs=5, with source 0 {we, addr 5, 0x11} and source 1 {we, addr 5, 0x22}, src0 pend=0 → rs_data=0x11. Source 0 we=0 → 0x22. No match → rf_rdata1. rs=0 with a matching waddr 0 → 0.
- Source 0 {we, addr 8, pend=1}, rt=8, use_rt=1 → stallreq=1 and stall_cnt increments. use_rt=0 → stallreq=0.
- stall[1]=Stop & stall[2]=NoStop → bubble: id_valid=0, id_inst=0. Flush with stall[1]=NoStop → register cleared. With CNT_W=4, 20 consecutive interlock cycles → stall_cnt=15.

Source files
------------

// File: rtl/id_bypass_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// id_bypass_ctrl_pkg
// Shared definitions for the decode-side front end: stall bus layout and
// encodings, IF->ID bus width, per-source bypass record width, the hold-buffer
// FSM states and the IF/ID register action decode.
// ---------------------------------------------------------------------------
package id_bypass_ctrl_pkg;

  // Stall bus: one bit per pipeline register, bit 1 = IF/ID, bit 2 = ID/EX.
  localparam int   STALL_BUS_W = 6;
  localparam int   IF_ID_BIT   = 1;
  localparam int   ID_EX_BIT   = 2;
  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;

  // IF->ID bus is {ce, pc[31:0]}.
  localparam int IF_TO_ID_WD = 33;

  // Register-file address width.
  localparam int REG_ADDR_W = 5;

  // One bypass source record: {we, pend, waddr[4:0], wdata[DATA_W-1:0]}.
  function automatic int fwd_src_wd(input int data_w);
    return 1 + 1 + REG_ADDR_W + data_w;
  endfunction
  localparam int FWD_SRC_WD = fwd_src_wd(32);

  // Instruction hold buffer states.
  typedef enum logic {
    ST_PASS = 1'b0,   // id_inst follows the SRAM read data
    ST_HELD = 1'b1    // id_inst comes from the captured word
  } hold_state_e;

  // What the IF/ID register does at the next edge (reset handled separately).
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_LOAD  = 2'd1,
    ACT_CLEAR = 2'd2
  } ifid_act_e;

  // Flush beats everything; a stop at IF/ID with ID/EX moving inserts a bubble.
  function automatic ifid_act_e ifid_action(input logic flush,
                                            input logic if_stop,
                                            input logic ex_stop);
    if (flush) begin
      return ACT_CLEAR;
    end else if (if_stop && !ex_stop) begin
      return ACT_CLEAR;
    end else if (!if_stop) begin
      return ACT_LOAD;
    end else begin
      return ACT_HOLD;
    end
  endfunction

endpackage

// File: rtl/id_bypass_ctrl_if.sv
// ---------------------------------------------------------------------------
// id_bypass_ctrl_if
// Bypass bus from the later pipeline stages into decode. Source 0 is the
// youngest (EX); higher indices are older (MEM, WB, ...).
//   fwd_we    : per-source write enable
//   fwd_waddr : per-source destination, source i at [5i+4:5i]
//   fwd_wdata : per-source result, source i at [DATA_W*i +: DATA_W]
//   fwd_pend  : per-source "result not available yet" (load in EX)
// master = producing stages, slave = decode front end.
// ---------------------------------------------------------------------------
interface id_bypass_ctrl_if
  import id_bypass_ctrl_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32
) ();

  logic [NUM_FWD-1:0]            fwd_we;
  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_waddr;
  logic [DATA_W*NUM_FWD-1:0]     fwd_wdata;
  logic [NUM_FWD-1:0]            fwd_pend;

  modport master (output fwd_we, fwd_waddr, fwd_wdata, fwd_pend);
  modport slave  (input  fwd_we, fwd_waddr, fwd_wdata, fwd_pend);

endinterface

// File: rtl/id_fwd_sel.sv
// ---------------------------------------------------------------------------
// id_fwd_sel
// Priority operand bypass mux for one source operand.
//   i_addr      : operand register address (0 never forwards, reads as 0)
//   i_rf_rdata  : register file value used when no source matches
//   i_fwd_*     : flattened bypass bus, index 0 = youngest
//   o_data      : selected operand
//   o_hit       : some source matched
//   o_pend      : the winning (youngest matching) source is still pending
// ---------------------------------------------------------------------------
module id_fwd_sel
  import id_bypass_ctrl_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32
) (
  input  logic [REG_ADDR_W-1:0]         i_addr,
  input  logic [DATA_W-1:0]             i_rf_rdata,
  input  logic [NUM_FWD-1:0]            i_fwd_we,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] i_fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0]     i_fwd_wdata,
  input  logic [NUM_FWD-1:0]            i_fwd_pend,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_hit,
  output logic                          o_pend
);

  logic [NUM_FWD-1:0] w_match;
  logic [DATA_W-1:0]  w_data;
  logic               w_hit;
  logic               w_pend;
  logic               w_addr_nz;

  assign w_addr_nz = (i_addr != {REG_ADDR_W{1'b0}});

  // Per-source address match; $0 is never a match.
  always_comb begin
    w_match = {NUM_FWD{1'b0}};
    for (int i = 0; i < NUM_FWD; i++) begin
      w_match[i] = i_fwd_we[i] & w_addr_nz &
                   (i_fwd_waddr[REG_ADDR_W*i +: REG_ADDR_W] == i_addr);
    end
  end

  // Walk oldest to youngest so the youngest matching source lands last and wins.
  always_comb begin
    w_data = i_rf_rdata;
    w_hit  = 1'b0;
    w_pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      w_data = w_match[i] ? i_fwd_wdata[DATA_W*i +: DATA_W] : w_data;
      w_pend = w_match[i] ? i_fwd_pend[i] : w_pend;
      w_hit  = w_hit | w_match[i];
    end
  end

  assign o_data = w_addr_nz ? w_data : {DATA_W{1'b0}};
  assign o_hit  = w_hit;
  assign o_pend = w_pend;

endmodule

// File: rtl/id_bypass_ctrl.sv
// ---------------------------------------------------------------------------
// id_bypass_ctrl
// Decode-side front end: IF/ID pipeline register (stall/bubble/flush), an
// instruction hold buffer that keeps the SRAM word stable across multi-cycle
// stalls, an N-source priority operand bypass with load-use interlock, and a
// saturating interlock-cycle counter.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   i_stall            : stall bus (bit 1 IF/ID, bit 2 ID/EX)
//   i_flush            : kill the instruction entering/in ID
//   i_if_to_id_bus     : {ce, pc}
//   i_inst_sram_rdata  : instruction SRAM read data
//   i_use_rs/i_use_rt  : decoder says the operand is really read
//   i_rf_rdata1/2      : register file data for rs/rt
//   i_fwd              : bypass bus (slave side)
//   o_id_valid/o_id_pc : registered ID instruction state
//   o_id_inst          : stable instruction word, 0 when not valid
//   o_rs_addr/o_rt_addr: operand fields of o_id_inst
//   o_rs_data/o_rt_data: bypassed operands, 0 when not valid
//   o_stallreq         : load-use interlock request
//   o_stall_cnt        : saturating count of interlock cycles
// ---------------------------------------------------------------------------
module id_bypass_ctrl
  import id_bypass_ctrl_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_BUS_W-1:0] i_stall,
  input  logic                   i_flush,
  input  logic [IF_TO_ID_WD-1:0] i_if_to_id_bus,
  input  logic [31:0]            i_inst_sram_rdata,
  input  logic                   i_use_rs,
  input  logic                   i_use_rt,
  input  logic [DATA_W-1:0]      i_rf_rdata1,
  input  logic [DATA_W-1:0]      i_rf_rdata2,
  id_bypass_ctrl_if.slave        i_fwd,
  output logic                   o_id_valid,
  output logic [31:0]            o_id_pc,
  output logic [31:0]            o_id_inst,
  output logic [REG_ADDR_W-1:0]  o_rs_addr,
  output logic [REG_ADDR_W-1:0]  o_rt_addr,
  output logic [DATA_W-1:0]      o_rs_data,
  output logic [DATA_W-1:0]      o_rt_data,
  output logic                   o_stallreq,
  output logic [CNT_W-1:0]       o_stall_cnt
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  hold_state_e r_state;
  logic [CNT_W-1:0] r_stall_cnt;

  ifid_act_e         w_act;
  logic [31:0]       w_inst;
  logic [DATA_W-1:0] w_rs_sel;
  logic [DATA_W-1:0] w_rt_sel;
  logic              w_rs_hit;
  logic              w_rs_pend;
  logic              w_rt_hit;
  logic              w_rt_pend;
  logic              w_stallreq;
  logic              w_unused_stall;

  // Only the IF/ID and ID/EX stall bits matter here.
  assign w_unused_stall = ^{i_stall[STALL_BUS_W-1:ID_EX_BIT+1], i_stall[0]};

  assign w_act = ifid_action(i_flush,
                             i_stall[IF_ID_BIT] == STOP,
                             i_stall[ID_EX_BIT] == STOP);

  // IF/ID register plus hold-buffer FSM; the SRAM word is captured on the
  // first held edge because the SRAM output moves on once fetch advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_hold  <= 32'h0;
      r_state <= ST_PASS;
    end else begin
      case (w_act)
        ACT_LOAD: begin
          r_valid <= i_if_to_id_bus[IF_TO_ID_WD-1];
          r_pc    <= i_if_to_id_bus[31:0];
          r_state <= ST_PASS;
        end
        ACT_HOLD: begin
          if ((r_state == ST_PASS) && r_valid) begin
            r_state <= ST_HELD;
            r_hold  <= i_inst_sram_rdata;
          end else begin
            r_state <= r_state;
            r_hold  <= r_hold;
          end
        end
        ACT_CLEAR: begin
          r_valid <= 1'b0;
          r_pc    <= 32'h0;
          r_state <= ST_PASS;
        end
        default: begin
          r_valid <= 1'b0;
          r_pc    <= 32'h0;
          r_state <= ST_PASS;
        end
      endcase
    end
  end

  assign w_inst = (r_state == ST_HELD) ? r_hold :
                  (r_valid ? i_inst_sram_rdata : 32'h0);

  id_fwd_sel #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_fwd_rs (
    .i_addr      (w_inst[25:21]),
    .i_rf_rdata  (i_rf_rdata1),
    .i_fwd_we    (i_fwd.fwd_we),
    .i_fwd_waddr (i_fwd.fwd_waddr),
    .i_fwd_wdata (i_fwd.fwd_wdata),
    .i_fwd_pend  (i_fwd.fwd_pend),
    .o_data      (w_rs_sel),
    .o_hit       (w_rs_hit),
    .o_pend      (w_rs_pend)
  );

  id_fwd_sel #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_fwd_rt (
    .i_addr      (w_inst[20:16]),
    .i_rf_rdata  (i_rf_rdata2),
    .i_fwd_we    (i_fwd.fwd_we),
    .i_fwd_waddr (i_fwd.fwd_waddr),
    .i_fwd_wdata (i_fwd.fwd_wdata),
    .i_fwd_pend  (i_fwd.fwd_pend),
    .o_data      (w_rt_sel),
    .o_hit       (w_rt_hit),
    .o_pend      (w_rt_pend)
  );

  // Only the youngest match's pending flag counts; older pending results are shadowed.
  assign w_stallreq = r_valid & ((i_use_rs & w_rs_hit & w_rs_pend) |
                                 (i_use_rt & w_rt_hit & w_rt_pend));

  // Saturating interlock-cycle counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stallreq && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign o_id_valid  = r_valid;
  assign o_id_pc     = r_pc;
  assign o_id_inst   = w_inst;
  assign o_rs_addr   = w_inst[25:21];
  assign o_rt_addr   = w_inst[20:16];
  assign o_rs_data   = r_valid ? w_rs_sel : {DATA_W{1'b0}};
  assign o_rt_data   = r_valid ? w_rt_sel : {DATA_W{1'b0}};
  assign o_stallreq  = w_stallreq;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_bypass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_bypass_ctrl
// Directed scenarios plus a randomized run against a behavioural model of
// the decode front end (ID instruction, bypass priority, interlock, counter).
// ---------------------------------------------------------------------------
module tb_id_bypass_ctrl;
  import id_bypass_ctrl_pkg::*;

  localparam int NF = 3;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [32:0] if_bus;
  logic [31:0] sram;
  logic        use_rs, use_rt;
  logic [31:0] rf1, rf2;
  logic [NF-1:0] src_we, src_pend;
  logic [4:0]  src_addr [NF];
  logic [31:0] src_data [NF];

  logic        o_id_valid;
  logic [31:0] o_id_pc, o_id_inst;
  logic [4:0]  o_rs_addr, o_rt_addr;
  logic [31:0] o_rs_data, o_rt_data;
  logic        o_stallreq;
  logic [CW-1:0] o_stall_cnt;

  id_bypass_ctrl_if #(.NUM_FWD(NF), .DATA_W(DW)) fwd_if ();
  assign fwd_if.fwd_we    = src_we;
  assign fwd_if.fwd_pend  = src_pend;
  assign fwd_if.fwd_waddr = {src_addr[2], src_addr[1], src_addr[0]};
  assign fwd_if.fwd_wdata = {src_data[2], src_data[1], src_data[0]};

  id_bypass_ctrl #(.NUM_FWD(NF), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
    .i_if_to_id_bus(if_bus), .i_inst_sram_rdata(sram),
    .i_use_rs(use_rs), .i_use_rt(use_rt),
    .i_rf_rdata1(rf1), .i_rf_rdata2(rf2), .i_fwd(fwd_if),
    .o_id_valid(o_id_valid), .o_id_pc(o_id_pc), .o_id_inst(o_id_inst),
    .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_stallreq(o_stallreq), .o_stall_cnt(o_stall_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: what ID holds and which word it is stuck with, if any.
  bit          m_valid;
  logic [31:0] m_pc;
  bit          m_have_word;
  logic [31:0] m_word;
  int          m_cnt;

  function automatic logic [31:0] exp_inst();
    if (m_have_word) return m_word;
    return m_valid ? sram : 32'h0;
  endfunction

  function automatic void exp_operand(input logic [4:0] a, input logic [31:0] rf,
                                      output logic [31:0] d, output bit hit, output bit pnd);
    d = rf; hit = 1'b0; pnd = 1'b0;
    if (a == 5'd0) d = 32'h0;
    else begin
      for (int i = 0; i < NF; i++) begin
        if (!hit && src_we[i] && src_addr[i] == a) begin
          hit = 1'b1; d = src_data[i]; pnd = src_pend[i];
        end
      end
    end
    if (!m_valid) d = 32'h0;
  endfunction

  function automatic bit exp_stallreq();
    logic [31:0] inst, d;
    bit h1, p1, h2, p2;
    inst = exp_inst();
    exp_operand(inst[25:21], rf1, d, h1, p1);
    exp_operand(inst[20:16], rf2, d, h2, p2);
    return m_valid && ((use_rs && h1 && p1) || (use_rt && h2 && p2));
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    bit sr, if_stop, ex_stop;
    logic [31:0] cur_sram;
    sr = exp_stallreq();
    if_stop = stall[1];
    ex_stop = stall[2];
    cur_sram = sram;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_pc = 32'h0; m_have_word = 1'b0; m_word = 32'h0; m_cnt = 0;
    end else begin
      if (sr && m_cnt < CNT_MAX) m_cnt++;
      if (flush || (if_stop && !ex_stop)) begin
        m_valid = 1'b0; m_pc = 32'h0; m_have_word = 1'b0;
      end else if (!if_stop) begin
        m_valid = if_bus[32]; m_pc = if_bus[31:0]; m_have_word = 1'b0;
      end else if (!m_have_word && m_valid) begin
        m_have_word = 1'b1; m_word = cur_sram;
      end
    end
    #1;
  endtask

  task automatic clear_srcs();
    src_we = 3'b000; src_pend = 3'b000;
    for (int i = 0; i < NF; i++) begin src_addr[i] = 5'd0; src_data[i] = 32'h0; end
  endtask

  // Put a word into ID (one load edge) and keep it there with a full hold.
  task automatic load_inst(input logic [31:0] pc, input logic [31:0] inst);
    stall = 6'b000000; flush = 1'b0; if_bus = {1'b1, pc};
    tick();
    sram = inst;
    stall = 6'b000110;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 6'b000000; flush = 1'b0; if_bus = 33'h0; sram = 32'h13572468;
    use_rs = 1'b1; use_rt = 1'b1; rf1 = 32'hAAAA5555; rf2 = 32'h5555AAAA;
    clear_srcs();
    tick(); tick();
    rst = 1'b0;
    #2;
    n_cmp++; if (o_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_id_valid); end
    n_cmp++; if (o_id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", o_id_pc); end
    n_cmp++; if (o_id_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", o_id_inst); end
    n_cmp++; if (o_rs_data !== 32'h0 || o_rt_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h/%h want 0", o_rs_data, o_rt_data); end
    n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL reset_stallreq: got %b want 0", o_stallreq); end
    n_cmp++; if (o_stall_cnt !== 4'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", o_stall_cnt); end
  endtask

  task automatic test_load();
    use_rs = 1'b0; use_rt = 1'b0;
    stall = 6'b000000; if_bus = {1'b1, 32'hBFC00000};
    tick();
    sram = 32'h3C011234;
    #2;
    n_cmp++; if (o_id_valid !== 1'b1) begin n_bad++; $display("FAIL load_valid: got %b want 1", o_id_valid); end
    n_cmp++; if (o_id_pc !== 32'hBFC00000) begin n_bad++; $display("FAIL load_pc: got %h want bfc00000", o_id_pc); end
    n_cmp++; if (o_id_inst !== 32'h3C011234) begin n_bad++; $display("FAIL load_inst: got %h want 3c011234", o_id_inst); end
    n_cmp++; if (o_rs_addr !== 5'd0 || o_rt_addr !== 5'd1) begin n_bad++; $display("FAIL load_addr: got %0d/%0d want 0/1", o_rs_addr, o_rt_addr); end
    n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL load_stallreq: got %b want 0", o_stallreq); end
  endtask

  task automatic test_hold_stall();
    stall = 6'b000110; if_bus = {1'b1, 32'hBFC00004};
    #2;
    n_cmp++; if (o_id_inst !== 32'h3C011234) begin n_bad++; $display("FAIL hold_c1: got %h want 3c011234", o_id_inst); end
    tick();
    sram = 32'hDEADBEEF;
    #2;
    n_cmp++; if (o_id_inst !== 32'h3C011234) begin n_bad++; $display("FAIL hold_c2: got %h want 3c011234", o_id_inst); end
    tick();
    #2;
    n_cmp++; if (o_id_inst !== 32'h3C011234) begin n_bad++; $display("FAIL hold_c3: got %h want 3c011234", o_id_inst); end
    tick();
    stall = 6'b000000;
    #2;
    n_cmp++; if (o_id_inst !== 32'h3C011234 || o_id_pc !== 32'hBFC00000) begin n_bad++; $display("FAIL hold_c4: got %h pc %h want 3c011234 pc bfc00000", o_id_inst, o_id_pc); end
    tick();
    sram = 32'h24020001;
    #2;
    n_cmp++; if (o_id_inst !== 32'h24020001 || o_id_pc !== 32'hBFC00004) begin n_bad++; $display("FAIL hold_release: got %h pc %h want 24020001 pc bfc00004", o_id_inst, o_id_pc); end
  endtask

  task automatic test_bypass();
    load_inst(32'h80000100, {6'h00, 5'd5, 5'd8, 16'h0000});
    rf1 = 32'h00000099; rf2 = 32'h00000077;
    clear_srcs();
    src_we = 3'b011; src_addr[0] = 5'd5; src_data[0] = 32'h11; src_addr[1] = 5'd5; src_data[1] = 32'h22;
    #2;
    n_cmp++; if (o_rs_data !== 32'h11) begin n_bad++; $display("FAIL byp_youngest: got %h want 11", o_rs_data); end
    src_we = 3'b010;
    #2;
    n_cmp++; if (o_rs_data !== 32'h22) begin n_bad++; $display("FAIL byp_older: got %h want 22", o_rs_data); end
    src_we = 3'b100; src_addr[2] = 5'd8; src_data[2] = 32'h33;
    #2;
    n_cmp++; if (o_rs_data !== 32'h99 || o_rt_data !== 32'h33) begin n_bad++; $display("FAIL byp_rf_wb: got %h/%h want 99/33", o_rs_data, o_rt_data); end
    load_inst(32'h80000104, {6'h00, 5'd0, 5'd8, 16'h0000});
    clear_srcs();
    src_we = 3'b001; src_addr[0] = 5'd0; src_data[0] = 32'h11;
    #2;
    n_cmp++; if (o_rs_data !== 32'h0 || o_rt_data !== 32'h77) begin n_bad++; $display("FAIL byp_zero: got %h/%h want 0/77", o_rs_data, o_rt_data); end
  endtask

  task automatic test_interlock();
    load_inst(32'h80000200, {6'h23, 5'd3, 5'd8, 16'h0004});
    clear_srcs();
    use_rs = 1'b0; use_rt = 1'b1;
    src_we = 3'b001; src_addr[0] = 5'd8; src_data[0] = 32'h55; src_pend = 3'b001;
    #2;
    n_cmp++; if (o_stallreq !== 1'b1) begin n_bad++; $display("FAIL il_req: got %b want 1", o_stallreq); end
    tick();
    #2;
    n_cmp++; if (o_stall_cnt !== 4'(m_cnt) || m_cnt != 1) begin n_bad++; $display("FAIL il_cnt: got %0d want 1 (model %0d)", o_stall_cnt, m_cnt); end
    use_rt = 1'b0;
    #2;
    n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL il_unused: got %b want 0", o_stallreq); end
    use_rt = 1'b1; src_we = 3'b011; src_addr[1] = 5'd8; src_pend = 3'b010;
    #2;
    n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL il_shadow: got %b want 0", o_stallreq); end
    src_we = 3'b010;
    #2;
    n_cmp++; if (o_stallreq !== 1'b1) begin n_bad++; $display("FAIL il_older: got %b want 1", o_stallreq); end
    use_rt = 1'b0;
  endtask

  task automatic test_bubble_flush();
    stall = 6'b000010; sram = 32'h12345678;
    tick();
    #2;
    n_cmp++; if (o_id_valid !== 1'b0 || o_id_inst !== 32'h0) begin n_bad++; $display("FAIL bubble: got v%b %h want v0 0", o_id_valid, o_id_inst); end
    stall = 6'b000000; if_bus = {1'b1, 32'h80001000};
    tick();
    #2;
    n_cmp++; if (o_id_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre: got %b want 1", o_id_valid); end
    flush = 1'b1; if_bus = {1'b1, 32'h80001004};
    tick();
    flush = 1'b0;
    #2;
    n_cmp++; if (o_id_valid !== 1'b0 || o_id_pc !== 32'h0) begin n_bad++; $display("FAIL flush: got v%b pc %h want v0 0", o_id_valid, o_id_pc); end
  endtask

  task automatic test_saturate();
    rst = 1'b1; tick(); rst = 1'b0;
    load_inst(32'h80000300, {6'h00, 5'd1, 5'd8, 16'h0000});
    clear_srcs();
    use_rt = 1'b1; src_we = 3'b001; src_addr[0] = 5'd8; src_pend = 3'b001;
    repeat (20) tick();
    #2;
    n_cmp++; if (o_stall_cnt !== 4'hF || o_stallreq !== 1'b1) begin n_bad++; $display("FAIL saturate: got %h req %b want f req 1", o_stall_cnt, o_stallreq); end
    use_rt = 1'b0; clear_srcs();
  endtask

  task automatic test_random();
    logic [31:0] w, e_inst, e_rs, e_rt;
    bit h, p;
    int r;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 3);
      stall = (r == 0) ? 6'b000000 : (r == 1) ? 6'b000010 : 6'b000110;
      if_bus = {($urandom_range(0, 3) != 0), 32'($urandom)};
      w = $urandom; w[25:21] = 5'($urandom_range(0, 3)); w[20:16] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) sram = w;
      use_rs = 1'($urandom_range(0, 1)); use_rt = 1'($urandom_range(0, 1));
      rf1 = $urandom; rf2 = $urandom;
      src_we = 3'($urandom); src_pend = 3'($urandom);
      for (int i = 0; i < NF; i++) begin
        src_addr[i] = 5'($urandom_range(0, 3)); src_data[i] = $urandom;
      end
      #2;
      e_inst = exp_inst();
      exp_operand(e_inst[25:21], rf1, e_rs, h, p);
      exp_operand(e_inst[20:16], rf2, e_rt, h, p);
      n_cmp++; if (o_id_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, o_id_valid, m_valid); end
      n_cmp++; if (o_id_pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc c%0d: got %h want %h", c, o_id_pc, m_pc); end
      n_cmp++; if (o_id_inst !== e_inst) begin n_bad++; $display("FAIL rnd_inst c%0d: got %h want %h", c, o_id_inst, e_inst); end
      n_cmp++; if (o_rs_addr !== e_inst[25:21] || o_rt_addr !== e_inst[20:16]) begin n_bad++; $display("FAIL rnd_addr c%0d: got %0d/%0d", c, o_rs_addr, o_rt_addr); end
      n_cmp++; if (o_rs_data !== e_rs) begin n_bad++; $display("FAIL rnd_rs c%0d: got %h want %h", c, o_rs_data, e_rs); end
      n_cmp++; if (o_rt_data !== e_rt) begin n_bad++; $display("FAIL rnd_rt c%0d: got %h want %h", c, o_rt_data, e_rt); end
      n_cmp++; if (o_stallreq !== exp_stallreq()) begin n_bad++; $display("FAIL rnd_stallreq c%0d: got %b", c, o_stallreq); end
      n_cmp++; if (o_stall_cnt !== 4'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, o_stall_cnt, m_cnt); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_hold_stall();
    test_bypass();
    test_interlock();
    test_bubble_flush();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
